// File: rtl/pixel_unpacker.sv
`default_nettype none
// ============================================================================
// Module      : pixel_unpacker
// Description : AXI4-Stream video sink. Unpacks groups of three 32-bit words
//               into four 24-bit RGB pixels. Each pixel is presented through
//               a single-stage ready/valid output register. Start-of-frame
//               comes from tuser and line ends are derived from the word
//               position. Framing errors are flagged and completed frames
//               are counted.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_unpacker #(
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int COLOR_WIDTH   = 8
) (
    input  logic                   out_stream_aclk,
    input  logic                   periph_resetn,
    input  logic [31:0]            in_stream_tdata,
    input  logic [3:0]             in_stream_tkeep,
    input  logic                   in_stream_tlast,
    input  logic                   in_stream_tuser,
    input  logic                   in_stream_tvalid,
    output logic                   in_stream_tready,
    output logic [COLOR_WIDTH-1:0] pix_r,
    output logic [COLOR_WIDTH-1:0] pix_g,
    output logic [COLOR_WIDTH-1:0] pix_b,
    output logic                   pix_valid,
    input  logic                   pix_ready,
    output logic                   pix_sof,
    output logic                   pix_eol,
    output logic                   err_sof,
    output logic                   err_eol,
    input  logic                   err_clear,
    output logic [15:0]            frame_count
);

    // Words per line: every 4 pixels occupy 3 words.
    localparam int C_WPL  = SCREEN_WIDTH * 3 / 4;
    localparam int C_WC_W = (C_WPL > 1) ? $clog2(C_WPL) : 1;
    localparam int C_LC_W = (SCREEN_HEIGHT > 1) ? $clog2(SCREEN_HEIGHT) : 1;
    localparam logic [C_WC_W-1:0] C_WC_LAST = C_WC_W'(C_WPL - 1);
    localparam logic [C_LC_W-1:0] C_LC_LAST = C_LC_W'(SCREEN_HEIGHT - 1);

    // Phase within a 3-word group. PH3 is the extra cycle that emits the
    // fourth pixel, which is already complete in the hold register.
    typedef enum logic [1:0] {
        PH0 = 2'd0,
        PH1 = 2'd1,
        PH2 = 2'd2,
        PH3 = 2'd3
    } phase_t;

    phase_t              r_phase;
    phase_t              w_phase_n;
    phase_t              w_dec_phase;

    logic [23:0]         r_hold;
    logic [C_WC_W-1:0]   r_wc;
    logic [C_LC_W-1:0]   r_lc;
    logic [15:0]         r_frame_count;
    logic [23:0]         r_pix;
    logic                r_pix_valid;
    logic                r_pix_sof;
    logic                r_pix_eol;
    logic                r_err_sof;
    logic                r_err_eol;
    logic                r_p3_eol;    // pending P3 closes the line
    logic                r_p3_wrap;   // pending P3 closes the frame

    logic [23:0]         w_hold_n;
    logic [C_WC_W-1:0]   w_wc_n;
    logic [C_LC_W-1:0]   w_lc_n;
    logic [15:0]         w_frame_count_n;
    logic [23:0]         w_pix_n;
    logic                w_pix_valid_n;
    logic                w_pix_sof_n;
    logic                w_pix_eol_n;
    logic                w_err_sof_n;
    logic                w_err_eol_n;
    logic                w_p3_eol_n;
    logic                w_p3_wrap_n;

    logic                w_free;
    logic                w_accept;
    logic                w_resync;
    logic [C_WC_W-1:0]   w_wc_eff;
    logic [C_LC_W-1:0]   w_lc_eff;
    logic                w_last;
    logic                w_early;
    logic                w_line_end;
    logic                w_lc_wrap;
    logic [C_LC_W-1:0]   w_lc_inc;
    logic                w_unused;

    // Byte enables are expected to be all ones and are otherwise ignored.
    assign w_unused = ^in_stream_tkeep;

    // The output register can take a new pixel when it is empty or being drained.
    assign w_free           = !r_pix_valid || pix_ready;
    assign in_stream_tready = w_free && (r_phase != PH3);
    assign w_accept         = in_stream_tvalid && in_stream_tready;

    // tuser always marks word 0 of a line. Seen mid-group it forces a resync.
    assign w_resync    = w_accept && in_stream_tuser && (r_phase == PH1 || r_phase == PH2);
    assign w_dec_phase = in_stream_tuser ? PH0 : r_phase;
    assign w_wc_eff    = in_stream_tuser ? '0 : r_wc;
    assign w_lc_eff    = in_stream_tuser ? '0 : r_lc;

    // Line position decides where a line ends. tlast is only cross-checked.
    assign w_last      = (w_wc_eff == C_WC_LAST);
    assign w_early     = in_stream_tlast && !w_last;
    assign w_line_end  = w_last || w_early;
    assign w_lc_wrap   = (w_lc_eff == C_LC_LAST);
    assign w_lc_inc    = w_lc_wrap ? '0 : C_LC_W'(w_lc_eff + 1'b1);

    // Next-state and datapath decode. Defaults hold every register.
    always_comb begin
        w_phase_n       = r_phase;
        w_hold_n        = r_hold;
        w_wc_n          = r_wc;
        w_lc_n          = r_lc;
        w_frame_count_n = r_frame_count;
        w_pix_n         = r_pix;
        w_pix_valid_n   = r_pix_valid;
        w_pix_sof_n     = r_pix_sof;
        w_pix_eol_n     = r_pix_eol;
        w_p3_eol_n      = r_p3_eol;
        w_p3_wrap_n     = r_p3_wrap;
        w_err_sof_n     = r_err_sof && !err_clear;
        w_err_eol_n     = r_err_eol && !err_clear;

        if (w_free) begin
            w_pix_valid_n = 1'b0;
        end

        if (w_accept) begin
            w_pix_valid_n = 1'b1;
            w_pix_sof_n   = 1'b0;
            w_pix_eol_n   = 1'b0;
            w_p3_eol_n    = 1'b0;
            w_p3_wrap_n   = 1'b0;

            case (w_dec_phase)
                PH0: begin
                    w_pix_n     = in_stream_tdata[23:0];
                    w_hold_n    = {16'h0000, in_stream_tdata[31:24]};
                    w_pix_sof_n = in_stream_tuser;
                    w_phase_n   = PH1;
                end
                PH1: begin
                    w_pix_n   = {in_stream_tdata[15:0], r_hold[7:0]};
                    w_hold_n  = {8'h00, in_stream_tdata[31:16]};
                    w_phase_n = PH2;
                end
                default: begin
                    w_pix_n   = {in_stream_tdata[7:0], r_hold[15:0]};
                    w_hold_n  = in_stream_tdata[31:8];
                    w_phase_n = PH3;
                end
            endcase

            if (w_resync) begin
                w_err_sof_n = 1'b1;
            end

            if (w_line_end) begin
                w_wc_n = '0;
                w_lc_n = w_lc_inc;
                if (in_stream_tlast != w_last) begin
                    w_err_eol_n = 1'b1;
                end
                if (w_early) begin
                    // Truncated line: drop the pending fourth pixel and realign.
                    w_phase_n = PH0;
                    if (w_lc_wrap) begin
                        w_frame_count_n = r_frame_count + 16'd1;
                    end
                end else begin
                    w_p3_eol_n  = 1'b1;
                    w_p3_wrap_n = w_lc_wrap;
                end
            end else begin
                w_wc_n = C_WC_W'(w_wc_eff + 1'b1);
                w_lc_n = w_lc_eff;
            end
        end else if (r_phase == PH3 && w_free) begin
            w_pix_valid_n = 1'b1;
            w_pix_n       = r_hold;
            w_pix_sof_n   = 1'b0;
            w_pix_eol_n   = r_p3_eol;
            w_phase_n     = PH0;
            if (r_p3_wrap) begin
                w_frame_count_n = r_frame_count + 16'd1;
            end
        end
    end

    // Phase state register.
    always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
            r_phase <= PH0;
        end else begin
            r_phase <= w_phase_n;
        end
    end

    // Datapath, counters, output register and sticky error flags.
    always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
            r_hold        <= '0;
            r_wc          <= '0;
            r_lc          <= '0;
            r_frame_count <= '0;
            r_pix         <= '0;
            r_pix_valid   <= 1'b0;
            r_pix_sof     <= 1'b0;
            r_pix_eol     <= 1'b0;
            r_err_sof     <= 1'b0;
            r_err_eol     <= 1'b0;
            r_p3_eol      <= 1'b0;
            r_p3_wrap     <= 1'b0;
        end else begin
            r_hold        <= w_hold_n;
            r_wc          <= w_wc_n;
            r_lc          <= w_lc_n;
            r_frame_count <= w_frame_count_n;
            r_pix         <= w_pix_n;
            r_pix_valid   <= w_pix_valid_n;
            r_pix_sof     <= w_pix_sof_n;
            r_pix_eol     <= w_pix_eol_n;
            r_err_sof     <= w_err_sof_n;
            r_err_eol     <= w_err_eol_n;
            r_p3_eol      <= w_p3_eol_n;
            r_p3_wrap     <= w_p3_wrap_n;
        end
    end

    assign pix_r       = r_pix[16 +: COLOR_WIDTH];
    assign pix_g       = r_pix[8  +: COLOR_WIDTH];
    assign pix_b       = r_pix[0  +: COLOR_WIDTH];
    assign pix_valid   = r_pix_valid;
    assign pix_sof     = r_pix_sof;
    assign pix_eol     = r_pix_eol;
    assign err_sof     = r_err_sof;
    assign err_eol     = r_err_eol;
    assign frame_count = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_pixel_unpacker.sv
`default_nettype none
// ============================================================================
// Module      : tb_pixel_unpacker
// Description : Randomised scoreboard bench for pixel_unpacker using a small
//               frame geometry.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_unpacker;

    localparam int W   = 160;
    localparam int H   = 8;
    localparam int WPL = W * 3 / 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] tdata = '0;
    logic [3:0]  tkeep = 4'hF;
    logic        tlast = 1'b0;
    logic        tuser = 1'b0;
    logic        tvalid = 1'b0;
    logic        tready;
    logic [7:0]  pix_r, pix_g, pix_b;
    logic        pix_valid;
    logic        pix_ready = 1'b1;
    logic        pix_sof, pix_eol;
    logic        err_sof, err_eol;
    logic        err_clear = 1'b0;
    logic [15:0] frame_count;

    typedef struct packed {
        logic [23:0] pix;
        logic        sof;
        logic        eol;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   ready_mode = 0;   // 0: always ready, 1: random, 2: stalled
    bit   no_gap = 1'b0;
    bit   use_inc = 1'b0;
    int   inc_val = 0;
    int   eol_seen = 0;
    int   sof_seen = 0;

    pixel_unpacker #(
        .SCREEN_WIDTH (W),
        .SCREEN_HEIGHT(H),
        .COLOR_WIDTH  (8)
    ) dut (
        .out_stream_aclk (clk),
        .periph_resetn   (rstn),
        .in_stream_tdata (tdata),
        .in_stream_tkeep (tkeep),
        .in_stream_tlast (tlast),
        .in_stream_tuser (tuser),
        .in_stream_tvalid(tvalid),
        .in_stream_tready(tready),
        .pix_r           (pix_r),
        .pix_g           (pix_g),
        .pix_b           (pix_b),
        .pix_valid       (pix_valid),
        .pix_ready       (pix_ready),
        .pix_sof         (pix_sof),
        .pix_eol         (pix_eol),
        .err_sof         (err_sof),
        .err_eol         (err_eol),
        .err_clear       (err_clear),
        .frame_count     (frame_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Word k of a group is bits [32k+31:32k] of {P3,P2,P1,P0}.
    function automatic logic [31:0] word_of(input logic [23:0] p0, input logic [23:0] p1,
                                            input logic [23:0] p2, input logic [23:0] p3,
                                            input int k);
        logic [95:0] g;
        g = {p3, p2, p1, p0};
        return g[32*k +: 32];
    endfunction

    // Downstream ready pattern, changed just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       pix_ready = 1'b1;
                1:       pix_ready = ($urandom_range(0, 2) != 0);
                default: pix_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops the scoreboard on every output handshake and checks that a
    // stalled pixel stays put.
    initial begin
        logic        pv, pr;
        logic [25:0] pd;
        exp_t        e;
        pv = 1'b0;
        pr = 1'b0;
        pd = '0;
        forever begin
            @(negedge clk);
            if (pv && !pr && rstn) begin
                check("stall_valid_held", pix_valid, 1);
                check("stall_data_held", {pix_r, pix_g, pix_b, pix_sof, pix_eol}, pd);
            end
            if (pix_valid && pix_ready) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_pixel: got 0x%0h, expected none", {pix_r, pix_g, pix_b});
                end else begin
                    e = q.pop_front();
                    check("pixel", {pix_r, pix_g, pix_b, pix_sof, pix_eol}, {e.pix, e.sof, e.eol});
                end
                if (pix_eol) eol_seen++;
                if (pix_sof) sof_seen++;
            end
            pv = pix_valid;
            pr = pix_ready;
            pd = {pix_r, pix_g, pix_b, pix_sof, pix_eol};
        end
    end

    task automatic send_word(input logic [31:0] d, input bit u, input bit l);
        int n;
        if (!no_gap && $urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
        end
        tvalid = 1'b1;
        tdata  = d;
        tuser  = u;
        tlast  = l;
        n = 0;
        forever begin
            @(negedge clk);
            if (tready) break;
            n++;
            if (n > 1000) begin
                n_fail++;
                $display("FAIL word_accept_timeout: got no tready, expected acceptance");
                $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
                $fatal(1, "timeout");
            end
        end
        @(posedge clk);
        #1;
        tvalid = 1'b0;
        tdata  = $urandom;
        tuser  = 1'b0;
        tlast  = 1'b0;
    endtask

    // Sends one line; the reference stream is built from the pixel order:
    // word w completes pixel 4*(w/3)+(w%3), and word 2 of a group also
    // completes pixel 3 unless that word truncated the line.
    task automatic send_line(input bit u, input int early, input bit tlast_ok);
        logic [23:0] px[W];
        int          nw, g, k;
        bit          l;
        for (int i = 0; i < W; i++) begin
            px[i] = use_inc ? 24'(inc_val) : 24'($urandom);
            inc_val++;
        end
        nw = (early >= 0) ? early + 1 : WPL;
        for (int w = 0; w < nw; w++) begin
            g = w / 3;
            k = w % 3;
            q.push_back(exp_t'{pix: px[4*g+k], sof: (u && w == 0), eol: 1'b0});
            if (k == 2 && !(early >= 0 && w == nw - 1))
                q.push_back(exp_t'{pix: px[4*g+3], sof: 1'b0, eol: (w == WPL - 1)});
            l = (w == nw - 1) && ((early >= 0) || tlast_ok);
            send_word(word_of(px[4*g], px[4*g+1], px[4*g+2], px[4*g+3], k), u && w == 0, l);
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((q.size() != 0 || pix_valid) && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_remaining", q.size(), 0);
    endtask

    task automatic reset_dut();
        rstn = 1'b0;
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        err_clear = 1'b1;
        @(posedge clk);
        #1;
        err_clear = 1'b0;
    endtask

    initial begin
        int          n;
        logic [23:0] rp[4];

        // Reset state
        reset_dut();
        check("rst_pix_valid", pix_valid, 0);
        check("rst_pix_sof", pix_sof, 0);
        check("rst_pix_eol", pix_eol, 0);
        check("rst_err_sof", err_sof, 0);
        check("rst_err_eol", err_eol, 0);
        check("rst_frame_count", frame_count, 0);
        check("rst_tready", tready, 1);

        // Single known group, back to back
        no_gap = 1'b1;
        q.push_back(exp_t'{pix: 24'h332211, sof: 1'b1, eol: 1'b0});
        q.push_back(exp_t'{pix: 24'h665544, sof: 1'b0, eol: 1'b0});
        q.push_back(exp_t'{pix: 24'h998877, sof: 1'b0, eol: 1'b0});
        q.push_back(exp_t'{pix: 24'h00BBAA, sof: 1'b0, eol: 1'b0});
        send_word(32'h44332211, 1'b1, 1'b0);
        send_word(32'h88776655, 1'b0, 1'b0);
        send_word(32'h00BBAA99, 1'b0, 1'b0);
        check("tready_ph3", tready, 0);
        check("ph3_pixel_valid", pix_valid, 1);
        no_gap = 1'b0;
        wait_drain();

        // Full frame, incrementing pixels, random downstream stalls
        reset_dut();
        ready_mode = 1;
        use_inc = 1'b1;
        eol_seen = 0;
        sof_seen = 0;
        check("frame_count_before", frame_count, 0);
        for (int l = 0; l < H; l++) send_line(l == 0, -1, 1'b1);
        wait_drain();
        use_inc = 1'b0;
        check("frame_count_after", frame_count, 1);
        check("eol_pulses", eol_seen, H);
        check("sof_pulses", sof_seen, 1);
        check("frame_err_sof", err_sof, 0);
        check("frame_err_eol", err_eol, 0);

        // Early tlast on word 100, then a normal line
        send_line(1'b0, 100, 1'b1);
        send_line(1'b0, -1, 1'b1);
        wait_drain();
        check("early_tlast_err_eol", err_eol, 1);
        check("early_tlast_err_sof", err_sof, 0);
        pulse_clear();
        check("err_eol_cleared", err_eol, 0);

        // Missing tlast on the last word: flagged, line still ends normally
        send_line(1'b0, -1, 1'b0);
        send_line(1'b0, -1, 1'b1);
        wait_drain();
        check("missing_tlast_err_eol", err_eol, 1);
        pulse_clear();
        check("err_eol_cleared2", err_eol, 0);

        // tuser on word 1 of a group: that word restarts as word 0
        for (int i = 0; i < 4; i++) rp[i] = 24'($urandom);
        q.push_back(exp_t'{pix: rp[0], sof: 1'b1, eol: 1'b0});
        send_word(word_of(rp[0], rp[1], rp[2], rp[3], 0), 1'b1, 1'b0);
        send_line(1'b1, -1, 1'b1);
        wait_drain();
        check("resync_err_sof", err_sof, 1);
        check("resync_err_eol", err_eol, 0);
        pulse_clear();
        check("err_sof_cleared", err_sof, 0);
        check("frame_count_mid", frame_count, 1);

        // Downstream stall of 20 cycles with a pixel pending
        ready_mode = 2;
        fork
            send_line(1'b0, -1, 1'b1);
            begin
                n = 0;
                while (!pix_valid && n < 100) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                check("stall_pix_valid", pix_valid, 1);
                repeat (20) begin
                    @(negedge clk);
                    check("stall_tready", tready, 0);
                end
                ready_mode = 0;
            end
        join
        wait_drain();

        // Reset while in PH2 with a pixel pending
        reset_dut();
        no_gap = 1'b1;
        for (int i = 0; i < 4; i++) rp[i] = 24'($urandom);
        q.push_back(exp_t'{pix: rp[0], sof: 1'b1, eol: 1'b0});
        send_word(word_of(rp[0], rp[1], rp[2], rp[3], 0), 1'b1, 1'b0);
        send_word(word_of(rp[0], rp[1], rp[2], rp[3], 1), 1'b0, 1'b0);
        check("pre_reset_valid", pix_valid, 1);
        #1;
        rstn = 1'b0;
        #1;
        check("async_rst_pix_valid", pix_valid, 0);
        check("async_rst_tready", tready, 1);
        check("async_rst_sof", pix_sof, 0);
        q.delete();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        no_gap = 1'b0;
        ready_mode = 1;
        for (int l = 0; l < H; l++) send_line(l == 0, -1, 1'b1);
        wait_drain();
        check("post_reset_frame_count", frame_count, 1);
        check("post_reset_err_sof", err_sof, 0);
        check("post_reset_err_eol", err_eol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
